// File: rtl/if_fetch_ctrl_if.sv
// ----------------------------------------------------------------------------
// if_fetch_ctrl_if
//
// Purpose : AXI read-address / read-data channel bundle between the
//           instruction-fetch sequencer (master) and instruction memory or
//           its interconnect (slave).
//
// Signals : araddr/arid/arlen/arsize/arburst/arvalid  master -> slave
//           arready                                   slave  -> master
//           rdata/rresp/rlast/rvalid                  slave  -> master
//           rready                                    master -> slave
// ----------------------------------------------------------------------------
interface if_fetch_ctrl_if #(
    parameter int PC_W   = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4
);
    // Read address channel
    logic [PC_W-1:0]   araddr;
    logic [ID_W-1:0]   arid;
    logic [3:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic              arvalid;
    logic              arready;

    // Read data channel
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic              rvalid;
    logic              rready;

    modport master (
        output araddr, arid, arlen, arsize, arburst, arvalid, rready,
        input  arready, rdata, rresp, rlast, rvalid
    );

    modport slave (
        input  araddr, arid, arlen, arsize, arburst, arvalid, rready,
        output arready, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/if_fetch_ctrl.sv
// ----------------------------------------------------------------------------
// if_fetch_ctrl
//
// Purpose : Instruction-fetch sequencer. Owns the fetch PC, issues one
//           single-beat AXI read per instruction (one outstanding at a time),
//           and drives pc/instruction plus stall/flush into the IF/ID
//           pipeline register. A one-entry holding buffer absorbs downstream
//           stalls; fetches in flight when a branch redirects are drained and
//           discarded.
//
// Ports   : clk, rst          clock, asynchronous active-high reset
//           pipe_stall_i      downstream hazard/memory stall
//           redirect_i        branch/jump taken (EX)
//           redirect_pc_i     redirect target
//           axi               AXI read master (AR + R channels)
//           inst_pc_o         pc presented to IF/ID
//           inst_data_o       instruction presented to IF/ID
//           id_stall_o        IF/ID hold
//           id_flush_o        IF/ID load zero bubble
//           fetch_err_o       delivered instruction came back with rresp!=OKAY
// ----------------------------------------------------------------------------
module if_fetch_ctrl #(
    parameter int              PC_W     = 32,
    parameter int              DATA_W   = 32,
    parameter int              ID_W     = 4,
    parameter logic [ID_W-1:0]   ARID_VAL = '0,
    parameter logic [PC_W-1:0]   RESET_PC = '0,
    parameter logic [DATA_W-1:0] NOP_INST = DATA_W'(32'h0000_0013)
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                pipe_stall_i,
    input  logic                redirect_i,
    input  logic [PC_W-1:0]     redirect_pc_i,

    if_fetch_ctrl_if.master     axi,

    output logic [PC_W-1:0]     inst_pc_o,
    output logic [DATA_W-1:0]   inst_data_o,
    output logic                id_stall_o,
    output logic                id_flush_o,
    output logic                fetch_err_o
);

    typedef enum logic [2:0] {
        S_IDLE,     // one cycle after reset release
        S_ADDR,     // AR channel valid, waiting for arready
        S_DATA,     // waiting for the R beat of a live fetch
        S_HOLD,     // fetched instruction parked while ID is stalled
        S_DROP      // draining the R beat of a fetch made stale by a redirect
    } state_t;

    localparam logic [PC_W-1:0] PC_STEP = PC_W'(4);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t              state_q,    state_d;
    logic [PC_W-1:0]     req_pc_q,   req_pc_d;     // pc of current/next fetch
    logic [PC_W-1:0]     tgt_q,      tgt_d;        // redirect target parked until drain
    logic                pend_q,     pend_d;       // redirect seen before AR handshake
    logic [PC_W-1:0]     buf_pc_q,   buf_pc_d;
    logic [DATA_W-1:0]   buf_data_q, buf_data_d;
    logic                buf_err_q,  buf_err_d;
    logic                arvalid_q,  arvalid_d;
    logic                rready_q,   rready_d;

    // EX keeps redirect asserted while the pipe is stalled, so it only
    // takes effect in a cycle where the pipeline is moving.
    logic redirect_take;
    logic r_done;
    logic r_err;

    assign redirect_take = redirect_i & ~pipe_stall_i;
    // Single-beat bursts: every beat is also the last; rlast is still
    // qualified so a misbehaving slave cannot end a fetch early.
    assign r_done        = axi.rvalid & axi.rlast & rready_q;
    assign r_err         = |axi.rresp;

    // ------------------------------------------------------------------
    // AXI outputs
    // ------------------------------------------------------------------
    assign axi.araddr  = req_pc_q;
    assign axi.arid    = ARID_VAL;
    assign axi.arlen   = 4'd0;
    assign axi.arsize  = 3'b010;
    assign axi.arburst = 2'b01;
    assign axi.arvalid = arvalid_q;
    assign axi.rready  = rready_q;

    // ------------------------------------------------------------------
    // Next-state and IF/ID control
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        req_pc_d    = req_pc_q;
        tgt_d       = tgt_q;
        pend_d      = pend_q;
        buf_pc_d    = buf_pc_q;
        buf_data_d  = buf_data_q;
        buf_err_d   = buf_err_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;

        // Default: no instruction for ID this cycle -> zero bubble.
        inst_pc_o   = '0;
        inst_data_o = '0;
        id_stall_o  = pipe_stall_i;
        id_flush_o  = 1'b1;
        fetch_err_o = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (redirect_take) begin
                    req_pc_d = redirect_pc_i;
                end
                state_d   = S_ADDR;
                arvalid_d = 1'b1;
            end

            S_ADDR: begin
                // araddr is req_pc_q and is left untouched here, so the AR
                // payload stays stable until the handshake; a redirect is
                // parked in tgt instead.
                if (axi.arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    if (redirect_take) begin
                        tgt_d = redirect_pc_i;
                    end
                    if (pend_q || redirect_take) begin
                        state_d = S_DROP;
                    end else begin
                        state_d = S_DATA;
                    end
                end else if (redirect_take) begin
                    tgt_d  = redirect_pc_i;
                    pend_d = 1'b1;
                end
            end

            S_DATA: begin
                if (r_done) begin
                    rready_d = 1'b0;
                    if (redirect_take) begin
                        // Wrong-path instruction: drop it and refetch.
                        req_pc_d  = redirect_pc_i;
                        state_d   = S_ADDR;
                        arvalid_d = 1'b1;
                    end else begin
                        inst_pc_o   = req_pc_q;
                        inst_data_o = r_err ? NOP_INST : axi.rdata;
                        if (!pipe_stall_i) begin
                            id_stall_o  = 1'b0;
                            id_flush_o  = 1'b0;
                            fetch_err_o = r_err;
                            req_pc_d    = req_pc_q + PC_STEP;
                            state_d     = S_ADDR;
                            arvalid_d   = 1'b1;
                        end else begin
                            buf_pc_d   = req_pc_q;
                            buf_data_d = r_err ? NOP_INST : axi.rdata;
                            buf_err_d  = r_err;
                            state_d    = S_HOLD;
                        end
                    end
                end else if (redirect_take) begin
                    // Response still outstanding: must drain it first.
                    tgt_d   = redirect_pc_i;
                    state_d = S_DROP;
                end
            end

            S_HOLD: begin
                inst_pc_o   = buf_pc_q;
                inst_data_o = buf_data_q;
                if (redirect_take) begin
                    req_pc_d  = redirect_pc_i;
                    state_d   = S_ADDR;
                    arvalid_d = 1'b1;
                end else if (!pipe_stall_i) begin
                    id_stall_o  = 1'b0;
                    id_flush_o  = 1'b0;
                    fetch_err_o = buf_err_q;
                    req_pc_d    = req_pc_q + PC_STEP;
                    state_d     = S_ADDR;
                    arvalid_d   = 1'b1;
                end
            end

            S_DROP: begin
                // The latest redirect wins, including one in the drain cycle.
                if (redirect_take) begin
                    tgt_d = redirect_pc_i;
                end
                if (r_done) begin
                    rready_d  = 1'b0;
                    req_pc_d  = redirect_take ? redirect_pc_i : tgt_q;
                    pend_d    = 1'b0;
                    state_d   = S_ADDR;
                    arvalid_d = 1'b1;
                end
            end

            default: begin
                state_d   = S_IDLE;
                arvalid_d = 1'b0;
                rready_d  = 1'b0;
            end
        endcase

        // IF/ID gives stall priority over flush, so a taken redirect must
        // never be masked by a stall.
        if (redirect_take) begin
            id_stall_o = 1'b0;
            id_flush_o = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            req_pc_q   <= RESET_PC;
            tgt_q      <= RESET_PC;
            pend_q     <= 1'b0;
            buf_pc_q   <= '0;
            buf_data_q <= '0;
            buf_err_q  <= 1'b0;
            arvalid_q  <= 1'b0;
            rready_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_pc_q   <= req_pc_d;
            tgt_q      <= tgt_d;
            pend_q     <= pend_d;
            buf_pc_q   <= buf_pc_d;
            buf_data_q <= buf_data_d;
            buf_err_q  <= buf_err_d;
            arvalid_q  <= arvalid_d;
            rready_q   <= rready_d;
        end
    end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
module tb_if_fetch_ctrl;
    localparam int PC_W   = 32;
    localparam int DATA_W = 32;
    localparam int ID_W   = 4;
    localparam logic [ID_W-1:0]   ARID = 4'h5;
    localparam logic [DATA_W-1:0] NOP  = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic              pipe_stall  = 1'b0;
    logic              redirect    = 1'b0;
    logic [PC_W-1:0]   redirect_pc = '0;
    logic [PC_W-1:0]   inst_pc;
    logic [DATA_W-1:0] inst_data;
    logic              id_stall, id_flush, fetch_err;

    if_fetch_ctrl_if #(.PC_W(PC_W), .DATA_W(DATA_W), .ID_W(ID_W)) axi ();

    if_fetch_ctrl #(
        .PC_W(PC_W), .DATA_W(DATA_W), .ID_W(ID_W),
        .ARID_VAL(ARID), .RESET_PC(32'h0), .NOP_INST(NOP)
    ) dut (
        .clk(clk), .rst(rst),
        .pipe_stall_i(pipe_stall), .redirect_i(redirect), .redirect_pc_i(redirect_pc),
        .axi(axi),
        .inst_pc_o(inst_pc), .inst_data_o(inst_data),
        .id_stall_o(id_stall), .id_flush_o(id_flush), .fetch_err_o(fetch_err)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // ---------------- memory / slave model ----------------
    int           ar_delay = 0, r_delay = 0, ar_cnt = 0, r_cnt = 0;
    bit           r_pend = 0;
    logic [31:0]  r_addr = '0;
    logic [31:0]  err_addr = 32'h0000_000C;
    bit           rand_mode = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {~a[15:0], a[15:0]};
    endfunction

    function automatic bit is_err(input logic [31:0] a);
        return (a == err_addr) || (rand_mode && (a[6:2] == 5'd7));
    endfunction

    task automatic slave_reset();
        r_pend = 0; ar_cnt = 0; r_cnt = 0;
        axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rlast = 1'b0;
        axi.rresp = 2'b00; axi.rdata = 32'hDEAD_BEEF;
    endtask

    // Called just after the rising edge: present this cycle's slave outputs.
    task automatic slave_drive();
        axi.arready = axi.arvalid && (ar_cnt >= ar_delay);
        axi.rvalid  = r_pend && (r_cnt >= r_delay);
        axi.rlast   = axi.rvalid;
        axi.rdata   = axi.rvalid ? mem_word(r_addr) : 32'hDEAD_BEEF;
        axi.rresp   = (axi.rvalid && is_err(r_addr)) ? 2'b10 : 2'b00;
    endtask

    // Called at the falling edge: record handshakes that complete at the next edge.
    task automatic slave_sample();
        bit r_fire, ar_fire;
        r_fire  = axi.rvalid && axi.rready;
        ar_fire = axi.arvalid && axi.arready;
        if (ar_fire) chk("one_outstanding", 64'(r_pend && !r_fire), 64'd0);
        if (r_fire) r_pend = 0;
        else if (r_pend) r_cnt++;
        if (ar_fire) begin
            r_pend = 1; r_addr = axi.araddr; r_cnt = 0; ar_cnt = 0;
            if (rand_mode) begin
                ar_delay = $urandom_range(0, 3);
                r_delay  = $urandom_range(0, 3);
            end
        end else if (axi.arvalid) begin
            ar_cnt++;
        end
    endtask

    // ---------------- reference model ----------------
    // Program-order view: each delivered instruction is the one after the
    // previous delivery, or the latest honoured redirect target.
    logic [31:0] exp_pc = 32'h0;
    bit          prev_wait = 0;
    logic [31:0] prev_addr = '0;
    int          n_deliv = 0;

    task automatic model_check();
        bit rd_h;
        rd_h = redirect && !pipe_stall;
        chk("id_stall", 64'(id_stall), 64'(pipe_stall));
        chk("arid", 64'(axi.arid), 64'(ARID));
        chk("ar_fixed", 64'({axi.arlen, axi.arsize, axi.arburst}), 64'({4'd0, 3'b010, 2'b01}));
        if (prev_wait) begin
            chk("ar_hold_valid", 64'(axi.arvalid), 64'd1);
            chk("ar_hold_addr", 64'(axi.araddr), 64'(prev_addr));
        end
        if (rd_h) chk("flush_on_redirect", 64'(id_flush), 64'd1);
        if (id_flush === 1'b0) begin
            chk("deliver_pc", 64'(inst_pc), 64'(exp_pc));
            chk("deliver_data", 64'(inst_data), 64'(is_err(exp_pc) ? NOP : mem_word(exp_pc)));
            chk("deliver_err", 64'(fetch_err), 64'(is_err(exp_pc)));
            exp_pc = exp_pc + 32'd4;
            n_deliv++;
        end else begin
            chk("err_quiet", 64'(fetch_err), 64'd0);
        end
        if (rd_h) exp_pc = redirect_pc;
        prev_wait = axi.arvalid && !axi.arready;
        prev_addr = axi.araddr;
    endtask

    task automatic cycle(input bit ps, input bit rd, input logic [31:0] rpc);
        @(posedge clk);
        #1;
        slave_drive();
        pipe_stall  = ps;
        redirect    = rd;
        redirect_pc = rpc;
        @(negedge clk);
        model_check();
        slave_sample();
    endtask

    initial begin
        int base;
        slave_reset();
        // ---- reset state ----
        repeat (2) @(negedge clk);
        chk("rst_arvalid", 64'(axi.arvalid), 64'd0);
        chk("rst_rready", 64'(axi.rready), 64'd0);
        chk("rst_araddr", 64'(axi.araddr), 64'd0);
        chk("rst_flush", 64'(id_flush), 64'd1);
        chk("rst_stall", 64'(id_stall), 64'd0);
        chk("rst_inst", 64'({inst_pc, inst_data}), 64'd0);
        chk("rst_err", 64'(fetch_err), 64'd0);
        rst = 1'b0;                                  // cycle 0 = IDLE

        // ---- zero-wait fetch of 0x0, 0x4, 0x8 ----
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 0);
            chk("t1_arvalid", 64'(axi.arvalid), 64'd1);
            chk("t1_araddr", 64'(axi.araddr), 64'(i * 4));
            chk("t1_flush_addr", 64'(id_flush), 64'd1);
            cycle(0, 0, 0);
            chk("t1_flush_data", 64'(id_flush), 64'd0);
            chk("t1_inst_pc", 64'(inst_pc), 64'(i * 4));
            chk("t1_inst_data", 64'(inst_data), 64'(mem_word(32'(i * 4))));
        end

        // ---- bus error on 0xC ----
        cycle(0, 0, 0);
        chk("t5_araddr", 64'(axi.araddr), 64'h0C);
        cycle(0, 0, 0);
        chk("t5_inst", 64'(inst_data), 64'(NOP));
        chk("t5_err", 64'(fetch_err), 64'd1);
        cycle(0, 0, 0);
        chk("t5_next_addr", 64'(axi.araddr), 64'h10);
        chk("t5_err_pulse", 64'(fetch_err), 64'd0);
        cycle(0, 0, 0);
        chk("t5_deliver_10", 64'(inst_pc), 64'h10);

        // ---- pipe_stall during R handshake of 0x14 ----
        cycle(0, 0, 0);
        chk("t3_araddr", 64'(axi.araddr), 64'h14);
        for (int i = 0; i < 4; i++) begin
            cycle(1, 0, 0);
            chk("t3_stall", 64'(id_stall), 64'd1);
            chk("t3_no_ar", 64'(axi.arvalid), 64'd0);
        end
        cycle(0, 0, 0);
        chk("t3_release_flush", 64'(id_flush), 64'd0);
        chk("t3_release_pc", 64'(inst_pc), 64'h14);

        // ---- slow arready with redirect before handshake ----
        ar_delay = 3;
        cycle(0, 0, 0);
        chk("t2_araddr0", 64'(axi.araddr), 64'h18);
        cycle(0, 1, 32'h100);
        chk("t2_araddr1", 64'(axi.araddr), 64'h18);
        cycle(0, 0, 0);
        chk("t2_araddr2", 64'(axi.araddr), 64'h18);
        cycle(0, 0, 0);
        chk("t2_hs_valid", 64'(axi.arvalid), 64'd1);
        chk("t2_hs_addr", 64'(axi.araddr), 64'h18);
        ar_delay = 0;
        cycle(0, 0, 0);
        chk("t2_drop_flush", 64'(id_flush), 64'd1);
        chk("t2_drop_rready", 64'(axi.rready), 64'd1);
        cycle(0, 0, 0);
        chk("t2_new_addr", 64'(axi.araddr), 64'h100);
        cycle(0, 0, 0);
        chk("t2_deliver", 64'(inst_pc), 64'h100);

        // ---- redirect in the R handshake cycle ----
        cycle(0, 0, 0);
        chk("t4_araddr", 64'(axi.araddr), 64'h104);
        cycle(0, 1, 32'h200);
        chk("t4_flush", 64'(id_flush), 64'd1);
        chk("t4_stall", 64'(id_stall), 64'd0);
        cycle(0, 0, 0);
        chk("t4_new_addr", 64'(axi.araddr), 64'h200);
        cycle(0, 0, 0);
        chk("t4_deliver", 64'(inst_pc), 64'h200);

        // ---- reset while in DATA ----
        cycle(0, 0, 0);
        @(posedge clk);
        #1;
        chk("t6_in_data", 64'(axi.rready), 64'd1);
        rst = 1'b1;
        slave_reset();
        #1;
        chk("t6_arvalid", 64'(axi.arvalid), 64'd0);
        chk("t6_rready", 64'(axi.rready), 64'd0);
        chk("t6_flush", 64'(id_flush), 64'd1);
        exp_pc = 32'h0; prev_wait = 0;
        @(negedge clk);
        rst = 1'b0;
        cycle(0, 0, 0);
        chk("t6_first_addr", 64'(axi.araddr), 64'h0);
        chk("t6_first_valid", 64'(axi.arvalid), 64'd1);
        cycle(0, 0, 0);
        chk("t6_deliver", 64'(inst_pc), 64'h0);

        // ---- randomized traffic against the model ----
        rand_mode = 1;
        base = n_deliv;
        for (int i = 0; i < 4000; i++) begin
            cycle(($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0),
                  {22'd0, 8'($urandom_range(0, 255)), 2'b00});
        end
        chk("rand_progress", 64'((n_deliv - base) > 50), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
